// File: rtl/zreg_pkg.sv
// zreg_pkg: shared collection-FSM state type and lane-count limit for zreg_bank.
package zreg_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, READY} state_t;
  localparam int MAX_CORES = 16;
endpackage

// File: rtl/zreg_lane.sv
// zreg_lane: one flag lane; registers zero (and, with ZREG_NFLAG_EN, negative) flag on write.
module zreg_lane #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_wr,
`ifdef ZREG_NFLAG_EN
  output logic             o_n,
`endif
  output logic             o_z
);
  always_ff @(posedge clk or posedge rst)
    if (rst) o_z <= 1'b0;
    else if (i_wr) o_z <= ~|i_data;
`ifdef ZREG_NFLAG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) o_n <= 1'b0;
    else if (i_wr) o_n <= i_data[WIDTH-1];
`endif
endmodule

// File: rtl/zreg_bank.sv
// zreg_bank: per-core zero flags plus an all/any-zero snapshot taken once every lane has written.
// Define ZREG_NFLAG_EN to add the per-lane negative flag output Nout.
module zreg_bank
  import zreg_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CORES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CORES*WIDTH-1:0] dataIn,
  input  logic [CORES-1:0]       wrEn,
  input  logic                   clrAgg,
  output logic [CORES-1:0]       Zout,
`ifdef ZREG_NFLAG_EN
  output logic [CORES-1:0]       Nout,
`endif
  output logic                   aggValid,
  output logic                   allZ,
  output logic                   anyZ,
  output logic                   dupErr
);
  state_t           r_state, w_state_nxt;
  logic [CORES-1:0] r_seen, w_seen_nxt, w_z_nxt;
  logic             r_allz, r_anyz, r_dup, w_dup_nxt, w_cap;
  genvar i;
  generate
    for (i = 0; i < CORES; i++) begin : g_lane
      zreg_lane #(.WIDTH(WIDTH)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .i_data (dataIn[i*WIDTH +: WIDTH]),
        .i_wr   (wrEn[i]),
`ifdef ZREG_NFLAG_EN
        .o_n    (Nout[i]),
`endif
        .o_z    (Zout[i])
      );
      // Snapshot must include writes landing on the same edge
      assign w_z_nxt[i] = wrEn[i] ? ~|dataIn[i*WIDTH +: WIDTH] : Zout[i];
    end
  endgenerate
  always_comb begin
    w_state_nxt = r_state;
    w_seen_nxt  = r_seen;
    w_dup_nxt   = r_dup;
    w_cap       = 1'b0;
    if (clrAgg || r_state == IDLE) begin
      w_seen_nxt  = wrEn;
      w_dup_nxt   = r_dup & ~clrAgg;
      w_state_nxt = ~|wrEn ? IDLE : (&wrEn ? READY : COLLECT);
      w_cap       = &wrEn;
    end else if (r_state == COLLECT) begin
      w_seen_nxt  = r_seen | wrEn;
      w_dup_nxt   = r_dup | (|(r_seen & wrEn));
      w_state_nxt = &w_seen_nxt ? READY : COLLECT;
      w_cap       = &w_seen_nxt;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_seen  <= '0;
      r_dup   <= 1'b0;
      r_allz  <= 1'b0;
      r_anyz  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_seen  <= w_seen_nxt;
      r_dup   <= w_dup_nxt;
      if (w_cap) begin
        r_allz <= &w_z_nxt;
        r_anyz <= |w_z_nxt;
      end
    end
  assign aggValid = r_state == READY;
  assign allZ     = aggValid & r_allz;
  assign anyZ     = aggValid & r_anyz;
  assign dupErr   = r_dup;
endmodule
